fixed_point_serial_add: RTL and testbench

//   Digit-serial two's-complement adder, the additive counterpart of FixedPointSubtract.

---
 rtl/fixed_point_serial_add.sv | 120 ++++++++++++
 tb/tb_fixed_point_serial_add.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_serial_add.sv
// Digit-serial two's-complement adder: DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on the operand and result sides.
module fixed_point_serial_add #(
    parameter int unsigned N     = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         carry_out,
    output logic         overflow
);

    localparam int unsigned NUM_DIGITS = N / DIGIT;
    localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned SUM_W      = DIGIT + 1;

    if ((N % DIGIT) != 0) begin : g_bad_digit
        $error("fixed_point_serial_add: DIGIT must divide N exactly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       a_sr;
    logic [N-1:0]       b_sr;
    logic [N-1:0]       c_sr;
    logic               cy;
    logic               a_msb;
    logic               b_msb;
    logic [CNT_W-1:0]   cnt;

    logic [SUM_W-1:0]   dsum_c;
    logic [N-1:0]       c_sr_nxt_c;
    logic               last_digit_c;

    // One digit of the ripple: low DIGIT bits of each operand plus the running carry
    assign dsum_c       = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + SUM_W'(cy);
    assign c_sr_nxt_c   = (c_sr >> DIGIT) | (N'(dsum_c[DIGIT-1:0]) << (N - DIGIT));
    assign last_digit_c = (cnt == CNT_W'(NUM_DIGITS - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (last_digit_c) state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // State register; handshake flags track the state they are decoded from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Operand capture, digit-serial shift and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            c_sr      <= '0;
            cy        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            c         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        cy    <= carry_in;
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> DIGIT;
                    b_sr <= b_sr >> DIGIT;
                    c_sr <= c_sr_nxt_c;
                    cy   <= dsum_c[DIGIT];
                    cnt  <= cnt + CNT_W'(1);
                    if (last_digit_c) begin
                        c         <= c_sr_nxt_c;
                        carry_out <= dsum_c[DIGIT];
                        overflow  <= (a_msb == b_msb) && (c_sr_nxt_c[N-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_serial_add.sv
// Bench for fixed_point_serial_add: directed corner cases and random ops on a
// 4-bit-digit instance and a single-digit (DIGIT=32) instance, scoreboard-checked.
module tb_fixed_point_serial_add;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic        cin;
    logic        iv0, iv1, or0, or1;
    logic        ir0, ir1, ovl0, ovl1, co0, co1, of0, of1;
    logic [31:0] c0, c1;
    logic        sel;
    logic        obs_in_ready, obs_out_valid, obs_co, obs_of;
    logic [31:0] obs_c;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fixed_point_serial_add #(.N(32), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .carry_in(cin), .out_valid(ovl0), .out_ready(or0),
        .c(c0), .carry_out(co0), .overflow(of0)
    );

    fixed_point_serial_add #(.N(32), .DIGIT(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .carry_in(cin), .out_valid(ovl1), .out_ready(or1),
        .c(c1), .carry_out(co1), .overflow(of1)
    );

    assign obs_in_ready  = sel ? ir1  : ir0;
    assign obs_out_valid = sel ? ovl1 : ovl0;
    assign obs_c         = sel ? c1   : c0;
    assign obs_co        = sel ? co1  : co0;
    assign obs_of        = sel ? of1  : of0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_iv(input logic v);
        if (sel) iv1 = v; else iv0 = v;
    endtask

    task automatic set_or(input logic v);
        if (sel) or1 = v; else or0 = v;
    endtask

    // Drive one operation on the selected instance; hold = cycles out_ready stays low,
    // inject = present a competing in_valid while the result is being held.
    task automatic do_op(input logic s, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tcin, input int hold, input logic inject);
        exp_t        e;
        exp_t        got;
        logic [32:0] full;
        int          lat;
        int          exp_lat;
        sel     = s;
        exp_lat = s ? 1 : 8;
        full    = {1'b0, ta} + {1'b0, tb_v} + 33'(tcin);
        e.sum   = full[31:0];
        e.co    = full[32];
        e.ov    = (ta[31] == tb_v[31]) && (full[31] != ta[31]);
        #1;
        check("in_ready_idle", 64'(obs_in_ready), 64'(1'b1));
        sb.push_back(e);
        a = ta; b = tb_v; cin = tcin;
        set_iv(1'b1);
        set_or(hold == 0);
        @(negedge clk);
        set_iv(1'b0);
        a = $urandom; b = $urandom; cin = 1'b0;
        lat = 0;
        while (!obs_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        got = sb.pop_front();
        if (obs_out_valid) begin
            check("sum", 64'(obs_c), 64'(got.sum));
            check("carry_out", 64'(obs_co), 64'(got.co));
            check("overflow", 64'(obs_of), 64'(got.ov));
            for (int i = 0; i < hold; i++) begin
                if (inject && i == 1) begin
                    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
                    set_iv(1'b1);
                end
                @(negedge clk);
                check("hold_valid", 64'(obs_out_valid), 64'(1'b1));
                check("hold_sum", 64'(obs_c), 64'(got.sum));
                check("hold_in_ready", 64'(obs_in_ready), 64'(1'b0));
            end
            set_iv(1'b0);
            set_or(1'b1);
            @(negedge clk);
            set_or(1'b0);
            check("released_valid", 64'(obs_out_valid), 64'(1'b0));
            check("released_ready", 64'(obs_in_ready), 64'(1'b1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b0; or1 = 1'b0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(ovl0), 64'(1'b0));
        check("rst_in_ready", 64'(ir0), 64'(1'b1));
        check("rst_c", 64'(c0), 64'(0));
        check("rst_carry_out", 64'(co0), 64'(1'b0));
        check("rst_overflow", 64'(of0), 64'(1'b0));
        check("rst_in_ready32", 64'(ir1), 64'(1'b1));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases on the 4-bit digit instance
        do_op(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 0, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Backpressure with a dropped in_valid in the hold window
        do_op(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 5, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("no_spurious_valid", 64'(ovl0), 64'(1'b0));
        end

        // Reset in the middle of RUN
        sel = 1'b0;
        a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b1;
        iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_busy", 64'(ir0), 64'(1'b0));
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(ovl0), 64'(1'b0));
        check("abort_in_ready", 64'(ir0), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0);

        // Single-digit instance: latency of one cycle
        do_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 2, 1'b0);

        // Random operations
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom;
            do_op(1'b0, ra, rb, 1'($urandom_range(1)), $urandom_range(2), 1'b0);
        end
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 16 == 0) rb = ~ra;
            do_op(1'b1, ra, rb, 1'($urandom_range(1)), 0, 1'b0);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
